escritor_memoria: RTL and testbench

Byte-addressed 32-byte memory with a serial word-write engine and a combinational little-endian word read port. It is the write side of the processor's byte-organised memory: it accepts a 32-bit word plus a 5-bit byte address and stores it one byte per clock into a single-byte-wide write port. Its read port returns four consecutive bytes, assembled little-endian, in the same layout the instruction fetch path uses.

---
 rtl/escritor_memoria.sv | 165 ++++++++++++++++
 tb/tb_escritor_memoria.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/escritor_memoria.sv
`default_nettype none
// ============================================================================
// Module      : escritor_memoria
// Description : 32-byte byte-addressed memory. A two-state FSM stores a
//               32-bit word one byte per clock, little-endian, starting at a
//               5-bit byte address (wrapping modulo 32). A combinational port
//               reads four consecutive bytes as a little-endian word.
//               Optional feature macro: ESCRITOR_BYTE_MASK_EN adds a 4-bit
//               ByteMask input that selects which byte slots are stored.
// Revision    : 1.0 - initial release
// ============================================================================
module escritor_memoria #(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            WriteEnable,
    input  logic [4:0]      WriteAddress,
    input  logic [SIZE-1:0] WriteData,
`ifdef ESCRITOR_BYTE_MASK_EN
    input  logic [3:0]      ByteMask,
`endif
    output logic            Busy,
    output logic            Done,
    input  logic [4:0]      ReadAddress,
    output logic [SIZE-1:0] ReadData
);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_WRITE = 1'b1;

    logic [0:0]      r_state;
    logic [0:0]      w_state_next;
    logic [4:0]      r_addr;
    logic [SIZE-1:0] r_data;
    logic [1:0]      r_cnt;
    logic            r_busy;
    logic            r_done;

    logic            w_accept;
    logic            w_last;
    logic            w_byte_wr;
    logic            w_mask_bit;
    logic [4:0]      w_wr_addr;
    logic [7:0]      w_wr_byte;
    logic [7:0]      w_mem [SIZE];

`ifdef ESCRITOR_BYTE_MASK_EN
    logic [3:0]      r_mask;

    // Mask is captured with the data so later changes cannot affect a word in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask <= 4'b0000;
        end else if (w_accept) begin
            r_mask <= ByteMask;
        end
    end

    assign w_mask_bit = r_mask[r_cnt];
`else
    assign w_mask_bit = 1'b1;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: four byte slots per word, then back to idle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (WriteEnable) begin
                    w_state_next = c_WRITE;
                end
            end
            c_WRITE: begin
                if (r_cnt == 2'd3) begin
                    w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    // Output decode: acceptance, last slot and per-slot byte write strobe
    always_comb begin
        w_accept  = 1'b0;
        w_last    = 1'b0;
        w_byte_wr = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_accept = WriteEnable;
            end
            c_WRITE: begin
                w_last    = (r_cnt == 2'd3);
                w_byte_wr = w_mask_bit;
            end
            default: begin
                w_accept  = 1'b0;
            end
        endcase
    end

    // Busy follows the state being entered; Done marks the cycle after the last slot
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_next == c_WRITE);
            r_done <= w_last;
        end
    end

    // Request capture and byte-slot counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr <= 5'd0;
            r_data <= '0;
            r_cnt  <= 2'd0;
        end else if (w_accept) begin
            r_addr <= WriteAddress;
            r_data <= WriteData;
            r_cnt  <= 2'd0;
        end else if (r_state == c_WRITE) begin
            r_cnt  <= r_cnt + 2'd1;
        end
    end

    // 5-bit sum wraps modulo 32 naturally
    assign w_wr_addr = r_addr + {3'b000, r_cnt};
    assign w_wr_byte = r_data[{r_cnt, 3'b000} +: 8];

    // One byte register per location, preloaded with its own index; reset
    // deliberately leaves contents alone and only blocks a pending byte write
    for (genvar gi = 0; gi < SIZE; gi++) begin : g_mem
        logic [7:0] r_byte = 8'(gi);

        // Byte store when this location is the current slot target
        always_ff @(posedge clk) begin
            if (!reset && w_byte_wr && (w_wr_addr == 5'(gi))) begin
                r_byte <= w_wr_byte;
            end
        end

        assign w_mem[gi] = r_byte;
    end

    assign ReadData = {w_mem[ReadAddress + 5'd3],
                       w_mem[ReadAddress + 5'd2],
                       w_mem[ReadAddress + 5'd1],
                       w_mem[ReadAddress]};

    assign Busy = r_busy;
    assign Done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_escritor_memoria.sv
`default_nettype none
// ============================================================================
// Module      : tb_escritor_memoria
// Description : Self-checking bench for escritor_memoria. A byte-level model
//               of the memory predicts each word; expected words are queued
//               at acceptance and compared when Done is seen. Honors
//               ESCRITOR_BYTE_MASK_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_escritor_memoria;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        WriteEnable = 1'b0;
    logic [4:0]  WriteAddress = 5'd0;
    logic [31:0] WriteData = 32'd0;
    logic        Busy;
    logic        Done;
    logic [4:0]  ReadAddress = 5'd0;
    logic [31:0] ReadData;
    logic [3:0]  cur_mask = 4'hF;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] model_mem [32];

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] word;
    } exp_t;

    exp_t sb_q[$];

    escritor_memoria #(.SIZE(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .WriteEnable  (WriteEnable),
        .WriteAddress (WriteAddress),
        .WriteData    (WriteData),
`ifdef ESCRITOR_BYTE_MASK_EN
        .ByteMask     (cur_mask),
`endif
        .Busy         (Busy),
        .Done         (Done),
        .ReadAddress  (ReadAddress),
        .ReadData     (ReadData)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_word(input logic [4:0] a);
        return {model_mem[a + 5'd3], model_mem[a + 5'd2],
                model_mem[a + 5'd1], model_mem[a]};
    endfunction

    // One full transaction starting at a negedge; returns in the Done cycle.
    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input bit inject);
        logic [7:0]  old_b [4];
        logic [7:0]  new_b [4];
        logic [4:0]  ba;
        logic [31:0] exp_w;
        exp_t        e;
        WriteEnable  = 1'b1;
        WriteAddress = a;
        WriteData    = d;
        ReadAddress  = a;
        for (int j = 0; j < 4; j++) begin
            ba       = a + 5'(j);
            old_b[j] = model_mem[ba];
            new_b[j] = cur_mask[j] ? d[8*j +: 8] : old_b[j];
        end
        @(posedge clk);
        #1;
        WriteEnable = 1'b0;
        for (int j = 0; j < 4; j++) begin
            ba            = a + 5'(j);
            model_mem[ba] = new_b[j];
        end
        e.addr = a;
        e.word = model_word(a);
        sb_q.push_back(e);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            for (int j = 0; j < 4; j++) begin
                exp_w[8*j +: 8] = (j < k) ? new_b[j] : old_b[j];
            end
            n_checks++;
            if (Busy !== 1'b1) begin
                n_fail++;
                $display("FAIL busy_during_write slot=%0d got=%b want=1", k, Busy);
            end
            n_checks++;
            if (Done !== 1'b0) begin
                n_fail++;
                $display("FAIL done_during_write slot=%0d got=%b want=0", k, Done);
            end
            n_checks++;
            if (ReadData !== exp_w) begin
                n_fail++;
                $display("FAIL partial_read slot=%0d got=%h want=%h", k, ReadData, exp_w);
            end
            if (inject && k == 0) begin
                WriteEnable  = 1'b1;
                WriteAddress = 5'd16;
                WriteData    = 32'h55667788;
            end
            if (inject && k == 2) begin
                WriteEnable = 1'b0;
            end
        end
        @(negedge clk);
        n_checks++;
        if (Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_in_done_cycle got=%b want=0", Busy);
        end
        n_checks++;
        if (Done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_pulse got=%b want=1", Done);
        end
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty got=0 entries want=1");
        end else begin
            e = sb_q.pop_front();
            ReadAddress = e.addr;
            #1;
            if (ReadData !== e.word) begin
                n_fail++;
                $display("FAIL word_after_done addr=%0d got=%h want=%h", e.addr, ReadData, e.word);
            end
        end
    endtask

    task automatic idle_check();
        @(negedge clk);
        n_checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_done got busy=%b done=%b want busy=0 done=0", Busy, Done);
        end
    endtask

    task automatic read_check(input logic [4:0] a, input logic [31:0] want, input string name);
        ReadAddress = a;
        #1;
        n_checks++;
        if (ReadData !== want) begin
            n_fail++;
            $display("FAIL %s addr=%0d got=%h want=%h", name, a, ReadData, want);
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        WriteEnable = 1'b1;
        WriteData   = 32'hFFFFFFFF;
        repeat (2) @(posedge clk);
        #1;
        reset       = 1'b0;
        WriteEnable = 1'b0;
        @(negedge clk);
        n_checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got busy=%b done=%b want busy=0 done=0", Busy, Done);
        end
        read_check(5'd0,  32'h03020100, "reset_read0");
        read_check(5'd29, 32'h001F1E1D, "reset_read29");
    endtask

    task automatic test_basic_write();
        @(negedge clk);
        do_write(5'd4, 32'hDEADBEEF, 1'b0);
        idle_check();
        read_check(5'd4, 32'hDEADBEEF, "basic_read4");
        read_check(5'd0, 32'h03020100, "basic_read0");
    endtask

    task automatic test_wrap();
        @(negedge clk);
        do_write(5'd30, 32'hAABBCCDD, 1'b0);
        idle_check();
        read_check(5'd0,  32'h0302AABB, "wrap_read0");
        read_check(5'd31, 32'h02AABBCC, "wrap_read31");
        read_check(5'd30, 32'hAABBCCDD, "wrap_read30");
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk);
        WriteEnable  = 1'b1;
        WriteAddress = 5'd8;
        WriteData    = 32'h11223344;
        ReadAddress  = 5'd8;
        @(posedge clk);
        #1;
        WriteEnable = 1'b0;
        @(negedge clk);
        n_checks++;
        if (Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_busy_start got=%b want=1", Busy);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_abort got busy=%b done=%b want busy=0 done=0", Busy, Done);
        end
        @(negedge clk);
        n_checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_no_done got busy=%b done=%b want busy=0 done=0", Busy, Done);
        end
        model_mem[8] = 8'h44;
        model_mem[9] = 8'h33;
        read_check(5'd8, 32'h0B0A3344, "midreset_read8");
        read_check(5'd8, model_word(5'd8), "midreset_model8");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        do_write(5'd4, 32'h01234567, 1'b1);
        read_check(5'd16, 32'h13121110, "busy_req_ignored");
        do_write(5'd16, 32'h55667788, 1'b0);
        idle_check();
        read_check(5'd16, 32'h55667788, "reassert_read16");
        read_check(5'd4,  32'h01234567, "b2b_read4");
    endtask

`ifdef ESCRITOR_BYTE_MASK_EN
    task automatic test_byte_mask();
        @(negedge clk);
        cur_mask = 4'b0101;
        do_write(5'd12, 32'hCAFEF00D, 1'b0);
        idle_check();
        read_check(5'd12, 32'h0FFE0D0D, "mask_read12");
        cur_mask = 4'hF;
        @(negedge clk);
        cur_mask = 4'b0000;
        do_write(5'd20, 32'h99999999, 1'b0);
        idle_check();
        read_check(5'd20, 32'h17161514, "mask_zero_read20");
        cur_mask = 4'hF;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog expired got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            model_mem[i] = 8'(i);
        end
        test_reset();
        test_basic_write();
        test_wrap();
        test_reset_mid_write();
        test_back_to_back();
`ifdef ESCRITOR_BYTE_MASK_EN
        test_byte_mask();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
